rcv_controller: RTL and testbench

Sequencing controller for the UART receive datapath. Watches the synchronized serial line for a start bit and times each bit period. Pulses `shift_enable` at every data-bit mid-point so the 8-bit serial-to-parallel shift register captures the line. Validates the stop bit, loads the receive buffer, and maintains the `data_ready`, `framing_error` and `overrun_error` status flags for the host side.

---
 rtl/uart_rcv_pkg.sv | 28 ++
 rtl/rcv_timer.sv | 46 ++++
 rtl/rcv_controller.sv | 175 +++++++++++++++++
 tb/tb_rcv_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rcv_pkg.sv
// -----------------------------------------------------------------------------
// uart_rcv_pkg
// Shared types and defaults for the UART receive controller.
//   rcv_state_t       : controller state encoding
//   DEF_CLKS_PER_BIT  : default clock cycles per serial bit
//   DEF_NUM_DATA_BITS : default data bits per frame
//   timer_width()     : bit-period counter width for a given CLKS_PER_BIT
// -----------------------------------------------------------------------------
package uart_rcv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      LOAD
   } rcv_state_t;

   localparam int DEF_CLKS_PER_BIT  = 10;
   localparam int DEF_NUM_DATA_BITS = 8;

   // Counter only has to reach CLKS_PER_BIT-1.
   function automatic int timer_width(input int clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/rcv_timer.sv
// -----------------------------------------------------------------------------
// rcv_timer
// Bit-period counter for the UART receive controller. Counts while enabled and
// wraps after reaching the rollover value; a clear forces it back to zero.
//   clk            in  : system clock
//   n_rst          in  : asynchronous active-low reset
//   i_clear        in  : synchronous clear (wins over enable)
//   i_enable       in  : count enable
//   i_rollover_val in  : terminal count (CLKS_PER_BIT-1)
//   o_half         out : count is at the half-period point (rollover_val/2)
//   o_full         out : count is at the terminal count
// -----------------------------------------------------------------------------
module rcv_timer
   import uart_rcv_pkg::*;
#(
   parameter int WIDTH = timer_width(DEF_CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_rollover_val,
   output logic             o_half,
   output logic             o_full
);

   logic [WIDTH-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         if (r_count == i_rollover_val) r_count <= '0;
         else                           r_count <= r_count + 1'b1;
      end
   end

   // For an even period, (period-1)>>1 is the last cycle of the first half.
   assign o_full = (r_count == i_rollover_val);
   assign o_half = (r_count == (i_rollover_val >> 1));

endmodule

// File: rtl/rcv_controller.sv
// -----------------------------------------------------------------------------
// rcv_controller
// Sequencing controller for the UART receive datapath: start-bit detection,
// mid-bit sampling strobes for the shift register, stop-bit check, buffer load
// and host status flags.
//   clk           in  : system clock
//   n_rst         in  : asynchronous active-low reset
//   serial_in     in  : synchronized receive line, idle high
//   data_read     in  : host consumed the buffered byte (one-cycle pulse)
//   shift_enable  out : data-bit sample strobe for the shift register
//   load_buffer   out : copy shift register into the receive buffer
//   data_ready    out : buffer holds an unread byte
//   framing_error out : last frame had a zero stop bit
//   overrun_error out : a byte was loaded over an unread one
//   busy          out : frame in progress
//   parity_error  out : even-parity check failed (only with RCV_PARITY_EN)
// Build option: define RCV_PARITY_EN to add a parity bit between data and stop.
// CLKS_PER_BIT must be even and >= 4.
// -----------------------------------------------------------------------------
module rcv_controller
   import uart_rcv_pkg::*;
#(
   parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
   parameter int NUM_DATA_BITS = DEF_NUM_DATA_BITS
) (
   input  logic clk,
   input  logic n_rst,
   input  logic serial_in,
   input  logic data_read,
   output logic shift_enable,
   output logic load_buffer,
   output logic data_ready,
   output logic framing_error,
   output logic overrun_error,
`ifdef RCV_PARITY_EN
   output logic parity_error,
`endif
   output logic busy
);

   localparam int TW = timer_width(CLKS_PER_BIT);
   localparam int BW = $clog2(NUM_DATA_BITS + 1);
   localparam logic [TW-1:0] ROLLOVER_VAL = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT     = BW'(NUM_DATA_BITS - 1);

   rcv_state_t    r_state;
   rcv_state_t    w_next_state;
   logic          r_prev_line;
   logic [BW-1:0] r_bit_cnt;
   logic          r_data_ready;
   logic          r_framing_error;
   logic          r_overrun_error;
   logic          w_half;
   logic          w_full;
   logic          w_timer_clear;
   logic          w_timer_en;
   logic          w_start_ok;
   logic          w_stop_fail;

   // Every state change restarts the bit period; inside DATA the timer wraps
   // on its own after each sample point.
   assign w_timer_clear = (w_next_state != r_state);
   assign w_timer_en    = (r_state != IDLE);

   rcv_timer #(.WIDTH(TW)) u_timer (
      .clk            (clk),
      .n_rst          (n_rst),
      .i_clear        (w_timer_clear),
      .i_enable       (w_timer_en),
      .i_rollover_val (ROLLOVER_VAL),
      .o_half         (w_half),
      .o_full         (w_full)
   );

   assign w_start_ok  = (r_state == START) && w_half && !serial_in;
   assign w_stop_fail = (r_state == STOP)  && w_full && !serial_in;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: the default assignment at the top keeps every path assigned, so no
   // latch is inferred when a branch has nothing to change.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:   if (!serial_in && r_prev_line) w_next_state = START;
         START:  if (w_half) w_next_state = serial_in ? IDLE : DATA;
         DATA: begin
            if (w_full && (r_bit_cnt == LAST_BIT)) begin
`ifdef RCV_PARITY_EN
               w_next_state = PARITY;
`else
               w_next_state = STOP;
`endif
            end
         end
         PARITY: if (w_full) w_next_state = STOP;
         STOP:   if (w_full) w_next_state = serial_in ? LOAD : IDLE;
         LOAD:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs (state and timer only) ----------------
   always_comb begin
      busy         = (r_state != IDLE);
      shift_enable = (r_state == DATA) && w_full;
      load_buffer  = (r_state == LOAD);
   end

   // Previous line sample for edge detection; resets low so a line that is
   // already low at reset release is not mistaken for a start bit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_prev_line <= 1'b0;
      else        r_prev_line <= serial_in;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                r_bit_cnt <= '0;
      else if (r_state != DATA)  r_bit_cnt <= '0;
      else if (shift_enable)     r_bit_cnt <= r_bit_cnt + 1'b1;
   end

   // ---------------- host status flags ----------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_data_ready    <= 1'b0;
         r_framing_error <= 1'b0;
         r_overrun_error <= 1'b0;
      end else begin
         if (w_start_ok)       r_framing_error <= 1'b0;
         else if (w_stop_fail) r_framing_error <= 1'b1;

         // A load coinciding with a read hands the new byte straight over.
         if (load_buffer) begin
            r_data_ready <= 1'b1;
            if (r_data_ready && !data_read) r_overrun_error <= 1'b1;
            else if (data_read)             r_overrun_error <= 1'b0;
         end else if (data_read) begin
            r_data_ready    <= 1'b0;
            r_overrun_error <= 1'b0;
         end
      end
   end

   assign data_ready    = r_data_ready;
   assign framing_error = r_framing_error;
   assign overrun_error = r_overrun_error;

`ifdef RCV_PARITY_EN
   // Even parity: XOR of all data bits and the parity bit must be zero.
   logic r_parity_acc;
   logic r_parity_error;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_parity_acc   <= 1'b0;
         r_parity_error <= 1'b0;
      end else if (w_start_ok) begin
         r_parity_acc   <= 1'b0;
         r_parity_error <= 1'b0;
      end else begin
         if (shift_enable)                  r_parity_acc   <= r_parity_acc ^ serial_in;
         if ((r_state == PARITY) && w_full) r_parity_error <= r_parity_acc ^ serial_in;
      end
   end

   assign parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_rcv_controller.sv
// -----------------------------------------------------------------------------
// tb_rcv_controller
// Drives serial frames (directed and $urandom) into rcv_controller and checks
// every output each cycle against a frame-timeline model: events are predicted
// as offsets from the falling edge that opens each frame.
// -----------------------------------------------------------------------------
module tb_rcv_controller;

   localparam int CPB  = 10;
   localparam int NB   = 8;
   localparam int HALF = CPB / 2;
`ifdef RCV_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int STOP_O = HALF + (NB + PB + 1) * CPB;  // stop sample offset
   localparam int LOAD_O = STOP_O + 1;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic serial_in = 1'b1;
   logic data_read = 1'b0;
   logic shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy;
`ifdef RCV_PARITY_EN
   logic parity_error;
`endif

   rcv_controller #(.CLKS_PER_BIT(CPB), .NUM_DATA_BITS(NB)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .serial_in     (serial_in),
      .data_read     (data_read),
      .shift_enable  (shift_enable),
      .load_buffer   (load_buffer),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun_error (overrun_error),
`ifdef RCV_PARITY_EN
      .parity_error  (parity_error),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // timeline model
   bit m_active = 1'b0;
   int m_t0 = 0;
   int m_end = 0;
   bit m_good = 1'b0;
   bit m_prev = 1'b0;
   bit m_acc = 1'b0;
   bit m_dr = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;

   // stimulus / observation
   bit         line_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] cap = '0;
   int         rd_pct = 0;
   bit         last_rd = 1'b0;
   int         n_shift = 0, n_busy = 0, first_shift_c = -1, load_c = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit even_par(input logic [7:0] d);
      return ^d;
   endfunction

   task automatic model_reset();
      m_active = 1'b0; m_good = 1'b0; m_prev = 1'b0; m_acc = 1'b0;
      m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
   endtask

   // One clock cycle: drive inputs after the edge, check at the falling edge.
   task automatic run_cycle(input bit l, input bit r, input bit rst);
      int o;
      bit e_busy, e_shift, e_load;
      @(posedge clk);
      #1;
      serial_in = l;
      data_read = r;
      n_rst     = !rst;
      cyc++;
      if (rst) model_reset();
      o       = cyc - m_t0;
      e_busy  = m_active && (o >= 1) && (o <= m_end);
      e_shift = e_busy && (o >= HALF + CPB) && ((o - HALF) % CPB == 0) && ((o - HALF) / CPB <= NB);
      e_load  = e_busy && m_good && (o == LOAD_O);
      @(negedge clk);
      check("busy", busy, e_busy);
      check("shift_enable", shift_enable, e_shift);
      check("load_buffer", load_buffer, e_load);
      check("data_ready", data_ready, m_dr);
      check("framing_error", framing_error, m_fe);
      check("overrun_error", overrun_error, m_ov);
`ifdef RCV_PARITY_EN
      check("parity_error", parity_error, m_pe);
`endif
      if (busy) n_busy++;
      if (shift_enable) begin
         cap = {l, cap[7:1]};
         n_shift++;
         if (first_shift_c < 0) first_shift_c = cyc;
      end
      if (load_buffer) begin
         load_c = cyc;
         check("rx_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("rx_byte", cap, exp_q.pop_front());
      end
      if (n_rst) begin
         if (!e_busy) begin
            if (m_prev && !l) begin
               m_active = 1'b1; m_t0 = cyc; m_end = 1_000_000; m_good = 1'b0;
            end
         end else begin
            if (o == HALF) begin
               if (l) m_end = HALF;
               else begin m_fe = 1'b0; m_pe = 1'b0; m_acc = 1'b0; end
            end
            if (e_shift) m_acc = m_acc ^ l;
`ifdef RCV_PARITY_EN
            if (o == STOP_O - CPB) m_pe = m_acc ^ l;
`endif
            if (o == STOP_O) begin
               if (l) begin m_good = 1'b1; m_end = LOAD_O; end
               else   begin m_fe = 1'b1;   m_end = STOP_O; end
            end
         end
         if (e_load) begin
            if (m_dr && !r) m_ov = 1'b1;
            else if (r)     m_ov = 1'b0;
            m_dr = 1'b1;
         end else if (r) begin
            m_dr = 1'b0; m_ov = 1'b0;
         end
         m_prev = l;
      end
   endtask

   // rd_idx >= 0: single read pulse at that queue index; otherwise random reads.
   task automatic play_queue(input int rd_idx);
      int idx;
      bit r;
      idx = 0;
      while (line_q.size() > 0) begin
         if (rd_idx >= 0) r = (idx == rd_idx);
         else             r = !last_rd && ($urandom_range(99) < rd_pct);
         last_rd = r;
         run_cycle(line_q.pop_front(), r, 1'b0);
         idx++;
      end
   endtask

   task automatic idle(input int n, input int rd_idx);
      for (int i = 0; i < n; i++) line_q.push_back(1'b1);
      play_queue(rd_idx);
   endtask

   // Frame: start, LSB-first data (optional glitches away from mid-bit),
   // optional parity, stop, then idle gap.
   task automatic send_frame(input logic [7:0] d, input bit stop, input bit par,
                             input int gap, input bit glitchy);
      int off;
      int g;
      for (int i = 0; i < CPB; i++) line_q.push_back(1'b0);
      for (int b = 0; b < NB; b++) begin
         off = glitchy ? int'($urandom_range(CPB - 2)) : -1;
         if (off >= HALF) off++;
         for (int i = 0; i < CPB; i++) line_q.push_back((i == off) ? !d[b] : d[b]);
      end
`ifdef RCV_PARITY_EN
      for (int i = 0; i < CPB; i++) line_q.push_back(par);
`else
      if (par) off = 0;
`endif
      for (int i = 0; i < CPB; i++) line_q.push_back(stop);
      g = (!stop && gap < 1) ? 1 : gap;
      for (int i = 0; i < g; i++) line_q.push_back(1'b1);
      if (stop) exp_q.push_back(d);
   endtask

   task automatic false_start(input int low_cycles);
      for (int i = 0; i < CPB; i++) line_q.push_back(i >= low_cycles);
   endtask

   initial begin
      int start_c;
      // reset and idle line
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b1);
      idle(5, -1);

      // 0xA5, good stop: 8 shifts, first at +15, load at +96 (+106 with parity)
      start_c = cyc + 1; n_shift = 0; first_shift_c = -1; load_c = -1;
      send_frame(8'hA5, 1'b1, even_par(8'hA5), 3, 1'b0);
      play_queue(-1);
      check("a5_shift_count", n_shift, NB);
      check("a5_first_shift", first_shift_c - start_c, 15);
`ifdef RCV_PARITY_EN
      check("a5_load_offset", load_c - start_c, 106);
`else
      check("a5_load_offset", load_c - start_c, 96);
`endif
      check("a5_data_ready", data_ready, 1);
      check("a5_framing", framing_error, 0);

      // 3-cycle glitch: false start, no shifts, busy for 5 cycles
      n_shift = 0; n_busy = 0;
      false_start(3);
      idle(4, -1);
      check("glitch_shift_count", n_shift, 0);
      check("glitch_busy_cycles", n_busy, 5);

      // bad stop bit, then a good frame clears the framing error
      n_shift = 0;
      send_frame(8'h3C, 1'b0, even_par(8'h3C), 2, 1'b0);
      play_queue(-1);
      check("fe_shift_count", n_shift, NB);
      check("fe_set", framing_error, 1);
      send_frame(8'h5A, 1'b1, even_par(8'h5A), 2, 1'b0);
      play_queue(-1);
      check("fe_cleared", framing_error, 0);

      // overrun: read, two unread loads, one read clears both
      idle(2, 0);
      send_frame(8'h11, 1'b1, even_par(8'h11), 0, 1'b0);
      send_frame(8'h22, 1'b1, even_par(8'h22), 2, 1'b0);
      play_queue(-1);
      check("ovr_set", overrun_error, 1);
      idle(2, 0);
      check("ovr_read_dr", data_ready, 0);
      check("ovr_read_ov", overrun_error, 0);

      // load and read in the same cycle: stays ready, no overrun
      send_frame(8'h33, 1'b1, even_par(8'h33), 1, 1'b0);
      play_queue(-1);
      send_frame(8'h44, 1'b1, even_par(8'h44), 2, 1'b0);
      play_queue(LOAD_O);
      check("coincide_dr", data_ready, 1);
      check("coincide_ov", overrun_error, 0);

`ifdef RCV_PARITY_EN
      send_frame(8'h01, 1'b1, 1'b0, 2, 1'b0);
      play_queue(-1);
      check("par_bad", parity_error, 1);
      send_frame(8'h01, 1'b1, 1'b1, 2, 1'b0);
      play_queue(-1);
      check("par_good", parity_error, 0);
`endif

      // randomized frames, gaps, glitches and host reads
      for (int f = 0; f < 40; f++) begin
         int kind;
         logic [7:0] d;
         kind   = int'($urandom_range(9));
         d      = 8'($urandom());
         rd_pct = int'($urandom_range(6));
         if (kind == 0) false_start(1 + int'($urandom_range(4)));
         else send_frame(d, kind != 1, (kind == 2) ? !even_par(d) : even_par(d),
                         int'($urandom_range(4)), $urandom_range(1) == 1);
         play_queue(-1);
      end
      rd_pct = 0;

      // reset right after the 4th shift, then a quiet high line
      idle(3, -1);
      n_shift = 0;
      send_frame(8'hC3, 1'b1, even_par(8'hC3), 0, 1'b0);
      for (int i = 0; i < 48; i++) run_cycle(line_q.pop_front(), 1'b0, 1'b0);
      check("pre_reset_shifts", n_shift, 4);
      line_q.delete();
      exp_q.delete();
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 1'b1);
      n_shift = 0;
      idle(120, -1);
      check("post_reset_shifts", n_shift, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
